// File: rtl/rob_multi_if.sv
// Bundle of dispatch, writeback, commit and status signals for the multi-lane reorder buffer.
// The slave modport is the ROB side; the master modport is the pipeline side.
interface rob_multi_if #(
    parameter int DEPTH  = 16,
    parameter int DISP_W = 2,
    parameter int CMT_W  = 2,
    parameter int WB_W   = 2
);
    localparam int IW = $clog2(DEPTH);

    logic [DISP_W-1:0]         disp_valid;
    logic [DISP_W-1:0][31:0]   disp_pc;
    logic [DISP_W-1:0][4:0]    disp_dst;
    logic                      disp_ready;
    logic [DISP_W-1:0][IW-1:0] disp_idx;

    logic [WB_W-1:0]           wb_valid;
    logic [WB_W-1:0][IW-1:0]   wb_idx;
    logic [WB_W-1:0][31:0]     wb_data;
    logic [WB_W-1:0]           wb_exc;

    logic                      commit_stall;
    logic [CMT_W-1:0]          commit_valid;
    logic [CMT_W-1:0][4:0]     commit_dst;
    logic [CMT_W-1:0][31:0]    commit_data;
    logic [CMT_W-1:0][31:0]    commit_pc;

    logic                      exc_valid;
    logic [31:0]               exc_pc;
    logic                      flush;
    logic [IW:0]               count;

    modport slave (
        input  disp_valid, disp_pc, disp_dst, wb_valid, wb_idx, wb_data, wb_exc,
               commit_stall, flush,
        output disp_ready, disp_idx, commit_valid, commit_dst, commit_data, commit_pc,
               exc_valid, exc_pc, count
    );

    modport master (
        output disp_valid, disp_pc, disp_dst, wb_valid, wb_idx, wb_data, wb_exc,
               commit_stall, flush,
        input  disp_ready, disp_idx, commit_valid, commit_dst, commit_data, commit_pc,
               exc_valid, exc_pc, count
    );
endinterface

// File: rtl/rob_multi.sv
// Multi-lane reorder buffer: in-order allocation, out-of-order writeback, in-order commit
// with precise exception reporting at the head.
module rob_multi #(
    parameter int DEPTH  = 16,
    parameter int DISP_W = 2,
    parameter int CMT_W  = 2,
    parameter int WB_W   = 2
) (
    input logic        clk,
    input logic        resetn,
    rob_multi_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [DEPTH-1:0]       complete_q, complete_d;
    logic [DEPTH-1:0]       exc_q, exc_d;
    logic [DEPTH-1:0][31:0] pc_q, pc_d;
    logic [DEPTH-1:0][31:0] data_q, data_d;
    logic [DEPTH-1:0][4:0]  dst_q, dst_d;
    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [PW-1:0]          count_q, count_d;

    logic [PW-1:0]          free_slots;
    logic [IW-1:0]          head_idx;
    logic [CMT_W-1:0][IW-1:0] cmt_idx;
    logic [CMT_W-1:0]       cmt_ok;
    logic                   cmt_go;
    logic                   exc_fire;
    logic                   clear_all;
    logic                   disp_fire;
    logic [PW-1:0]          n_disp;
    logic [PW-1:0]          n_cmt;

    assign head_idx       = head_q[IW-1:0];
    assign free_slots     = PW'(DEPTH) - count_q;
    assign bus.disp_ready = free_slots >= PW'(DISP_W);
    assign bus.count      = count_q;
    assign disp_fire      = bus.disp_ready & bus.disp_valid[0];

    for (genvar i = 0; i < DISP_W; i++) begin : g_disp_idx
        assign bus.disp_idx[i] = tail_q[IW-1:0] + IW'(i);
    end

    for (genvar k = 0; k < CMT_W; k++) begin : g_cmt_out
        assign cmt_idx[k]         = head_idx + IW'(k);
        assign bus.commit_dst[k]  = dst_q[cmt_idx[k]];
        assign bus.commit_data[k] = data_q[cmt_idx[k]];
        assign bus.commit_pc[k]   = pc_q[cmt_idx[k]];
    end

    // Lanes commit as an unbroken prefix; an excepting entry stops the chain so it
    // is only ever reported once it sits at the head.
    always_comb begin
        cmt_ok = '0;
        cmt_go = !bus.commit_stall && !bus.flush;
        for (int k = 0; k < CMT_W; k++) begin
            cmt_go = cmt_go && valid_q[cmt_idx[k]] && complete_q[cmt_idx[k]]
                     && !exc_q[cmt_idx[k]] && (PW'(k) < count_q);
            cmt_ok[k] = cmt_go;
        end
    end

    assign exc_fire = !bus.commit_stall && !bus.flush && valid_q[head_idx]
                      && complete_q[head_idx] && exc_q[head_idx];
    assign bus.commit_valid = cmt_ok;
    assign bus.exc_valid    = exc_fire;
    assign bus.exc_pc       = pc_q[head_idx];
    assign clear_all        = bus.flush | exc_fire;

    always_comb begin
        n_disp = '0;
        n_cmt  = '0;
        for (int i = 0; i < DISP_W; i++) begin
            if (disp_fire) n_disp = n_disp + PW'(bus.disp_valid[i]);
        end
        for (int k = 0; k < CMT_W; k++) begin
            n_cmt = n_cmt + PW'(cmt_ok[k]);
        end
    end

    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        exc_d      = exc_q;
        pc_d       = pc_q;
        data_d     = data_q;
        dst_d      = dst_q;
        // Ascending port order lets the highest-numbered port win a same-index collision.
        for (int p = 0; p < WB_W; p++) begin
            if (bus.wb_valid[p] && valid_q[bus.wb_idx[p]]) begin
                complete_d[bus.wb_idx[p]] = 1'b1;
                data_d[bus.wb_idx[p]]     = bus.wb_data[p];
                exc_d[bus.wb_idx[p]]      = bus.wb_exc[p];
            end
        end
        for (int k = 0; k < CMT_W; k++) begin
            if (cmt_ok[k]) valid_d[cmt_idx[k]] = 1'b0;
        end
        for (int i = 0; i < DISP_W; i++) begin
            if (disp_fire && bus.disp_valid[i]) begin
                valid_d[bus.disp_idx[i]]    = 1'b1;
                complete_d[bus.disp_idx[i]] = 1'b0;
                exc_d[bus.disp_idx[i]]      = 1'b0;
                pc_d[bus.disp_idx[i]]       = bus.disp_pc[i];
                dst_d[bus.disp_idx[i]]      = bus.disp_dst[i];
            end
        end
        head_d  = head_q + n_cmt;
        tail_d  = tail_q + n_disp;
        count_d = count_q + n_disp - n_cmt;
        if (clear_all) begin
            valid_d    = '0;
            complete_d = '0;
            exc_d      = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q    <= '0;
            complete_q <= '0;
            exc_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            complete_q <= complete_d;
            exc_q      <= exc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Payload needs no reset: it is only observed behind a valid entry.
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        data_q <= data_d;
        dst_q  <= dst_d;
    end
endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi (DEPTH=8, 2 lanes everywhere) with an in-order commit scoreboard.
module tb_rob_multi;
    localparam int DEPTH  = 8;
    localparam int DISP_W = 2;
    localparam int CMT_W  = 2;
    localparam int WB_W   = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [31:0] data;
    } cmt_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    rob_multi_if #(.DEPTH(DEPTH), .DISP_W(DISP_W), .CMT_W(CMT_W), .WB_W(WB_W)) bus ();

    rob_multi #(.DEPTH(DEPTH), .DISP_W(DISP_W), .CMT_W(CMT_W), .WB_W(WB_W)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    cmt_t        sb[$];
    logic [31:0] pend_data[DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          tb_tail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.disp_valid   = '0;
        bus.disp_pc      = '0;
        bus.disp_dst     = '0;
        bus.wb_valid     = '0;
        bus.wb_idx       = '0;
        bus.wb_data      = '0;
        bus.wb_exc       = '0;
        bus.commit_stall = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic disp(input logic [1:0] lanes,
                        input logic [31:0] pc0, input logic [4:0] d0, input logic [31:0] dat0,
                        input logic [31:0] pc1, input logic [4:0] d1, input logic [31:0] dat1,
                        input logic [1:0] push, input bit fires);
        cmt_t e;
        int   idx;
        bus.disp_valid  = lanes;
        bus.disp_pc[0]  = pc0;
        bus.disp_pc[1]  = pc1;
        bus.disp_dst[0] = d0;
        bus.disp_dst[1] = d1;
        chk("disp_idx0", bus.disp_idx[0], tb_tail % DEPTH);
        chk("disp_idx1", bus.disp_idx[1], (tb_tail + 1) % DEPTH);
        if (fires) begin
            for (int i = 0; i < 2; i++) begin
                if (lanes[i]) begin
                    idx = (tb_tail + i) % DEPTH;
                    e.pc   = (i == 0) ? pc0 : pc1;
                    e.dst  = (i == 0) ? d0 : d1;
                    e.data = (i == 0) ? dat0 : dat1;
                    pend_data[idx] = e.data;
                    if (push[i]) sb.push_back(e);
                end
            end
            tb_tail = tb_tail + int'(lanes[0]) + int'(lanes[1]);
        end
    endtask

    task automatic wb(input int p, input int idx, input logic exc);
        bus.wb_valid[p] = 1'b1;
        bus.wb_idx[p]   = idx[2:0];
        bus.wb_data[p]  = pend_data[idx];
        bus.wb_exc[p]   = exc;
    endtask

    task automatic check_commit(input int n, input string tag);
        cmt_t e;
        logic [1:0] m;
        #1;
        m = (n == 0) ? 2'b00 : ((n == 1) ? 2'b01 : 2'b11);
        chk(tag, bus.commit_valid, m);
        for (int k = 0; k < n; k++) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("commit_pc", bus.commit_pc[k], e.pc);
                chk("commit_dst", bus.commit_dst[k], e.dst);
                chk("commit_data", bus.commit_data[k], e.data);
            end
        end
    endtask

    task automatic reset_dut(input int n);
        resetn = 1'b0;
        repeat (n) tick();
        resetn = 1'b1;
        tb_tail = 0;
    endtask

    initial begin
        idle();
        reset_dut(2);

        // reset state
        check_commit(0, "rst_commit");
        chk("rst_count", bus.count, 0);
        chk("rst_ready", bus.disp_ready, 1);
        chk("rst_exc", bus.exc_valid, 0);
        chk("rst_idx0", bus.disp_idx[0], 0);
        chk("rst_idx1", bus.disp_idx[1], 1);

        // out-of-order writeback, paired commit
        disp(2'b11, 32'h100, 5'd3, 32'hB, 32'h104, 5'd4, 32'hA, 2'b11, 1);
        check_commit(0, "a_c0");
        tick();
        chk("a_count2", bus.count, 2);
        wb(0, 1, 1'b0);
        check_commit(0, "a_c1");
        tick();
        wb(0, 0, 1'b0);
        check_commit(0, "a_c2");
        tick();
        check_commit(2, "a_commit2");
        chk("a_count_pre", bus.count, 2);
        tick();
        chk("a_count0", bus.count, 0);

        // fill to full, free two, wrap the tail
        reset_dut(1);
        for (int c = 0; c < 4; c++) begin
            chk("b_ready", bus.disp_ready, 1);
            disp(2'b11, 32'h300 + 8 * c, 5'(2 * c + 1), 32'hB000 + 2 * c,
                 32'h304 + 8 * c, 5'(2 * c + 2), 32'hB001 + 2 * c, 2'b11, 1);
            tick();
        end
        chk("b_full_count", bus.count, 8);
        chk("b_full_ready", bus.disp_ready, 0);
        disp(2'b11, 32'h3F0, 5'd9, 32'h0, 32'h3F4, 5'd9, 32'h0, 2'b00, 0);
        wb(0, 0, 1'b0);
        wb(1, 1, 1'b0);
        check_commit(0, "b_c_full");
        tick();
        chk("b_count_blocked", bus.count, 8);
        check_commit(2, "b_commit2");
        chk("b_ready_same_cycle", bus.disp_ready, 0);
        tick();
        chk("b_count6", bus.count, 6);
        chk("b_ready_after", bus.disp_ready, 1);
        disp(2'b11, 32'h400, 5'd0, 32'hC400, 32'h404, 5'd5, 32'hC404, 2'b11, 1);
        check_commit(0, "b_c_wrap");
        tick();
        chk("b_count8", bus.count, 8);
        for (int j = 0; j < 4; j++) begin
            wb(0, (2 + 2 * j) % DEPTH, 1'b0);
            wb(1, (3 + 2 * j) % DEPTH, 1'b0);
            check_commit((j == 0) ? 0 : 2, "b_drain");
            tick();
        end
        check_commit(2, "b_drain_last");
        tick();
        chk("b_count_end", bus.count, 0);

        // exception behind a committable entry
        reset_dut(1);
        disp(2'b11, 32'h200, 5'd1, 32'hC0, 32'h204, 5'd2, 32'hC1, 2'b01, 1);
        tick();
        disp(2'b01, 32'h208, 5'd3, 32'hC2, 32'h0, 5'd0, 32'h0, 2'b00, 1);
        wb(0, 0, 1'b0);
        wb(1, 1, 1'b1);
        check_commit(0, "c_c0");
        tick();
        wb(0, 2, 1'b0);
        check_commit(1, "c_lane0_only");
        chk("c_exc_early", bus.exc_valid, 0);
        tick();
        disp(2'b11, 32'h500, 5'd1, 32'h0, 32'h504, 5'd2, 32'h0, 2'b00, 0);
        check_commit(0, "c_c_exc");
        chk("c_exc_valid", bus.exc_valid, 1);
        chk("c_exc_pc", bus.exc_pc, 32'h204);
        tick();
        tb_tail = 0;
        check_commit(0, "c_c_after");
        chk("c_count0", bus.count, 0);
        chk("c_exc_clr", bus.exc_valid, 0);
        chk("c_idx0", bus.disp_idx[0], 0);

        // commit stall
        disp(2'b11, 32'h600, 5'd7, 32'hE0, 32'h604, 5'd0, 32'hE1, 2'b11, 1);
        tick();
        wb(0, 0, 1'b0);
        wb(1, 1, 1'b0);
        tick();
        bus.commit_stall = 1'b1;
        check_commit(0, "d_stalled");
        chk("d_exc", bus.exc_valid, 0);
        tick();
        chk("d_count_held", bus.count, 2);
        check_commit(2, "d_release");
        tick();
        chk("d_count0", bus.count, 0);

        // flush with 5 entries, concurrent dispatch and writeback
        disp(2'b11, 32'h700, 5'd1, 32'hF0, 32'h704, 5'd2, 32'hF1, 2'b00, 1);
        tick();
        disp(2'b11, 32'h708, 5'd3, 32'hF2, 32'h70C, 5'd4, 32'hF3, 2'b00, 1);
        tick();
        disp(2'b01, 32'h710, 5'd5, 32'hF4, 32'h0, 5'd0, 32'h0, 2'b00, 1);
        tick();
        chk("e_count5", bus.count, 5);
        wb(0, 2, 1'b0);
        wb(1, 3, 1'b0);
        tick();
        bus.flush = 1'b1;
        disp(2'b11, 32'h720, 5'd6, 32'h0, 32'h724, 5'd7, 32'h0, 2'b00, 0);
        wb(0, 4, 1'b0);
        check_commit(0, "e_flush_commit");
        chk("e_flush_exc", bus.exc_valid, 0);
        tick();
        tb_tail = 0;
        check_commit(0, "e_after_commit");
        chk("e_count0", bus.count, 0);
        chk("e_idx0", bus.disp_idx[0], 0);
        chk("e_idx1", bus.disp_idx[1], 1);
        chk("e_ready", bus.disp_ready, 1);

        // reset mid-operation with pending writebacks
        for (int c = 0; c < 3; c++) begin
            disp(2'b11, 32'h800 + 8 * c, 5'd1, 32'h1, 32'h804 + 8 * c, 5'd2, 32'h2, 2'b00, 1);
            tick();
        end
        chk("f_count6", bus.count, 6);
        resetn = 1'b0;
        wb(0, 0, 1'b0);
        wb(1, 1, 1'b1);
        tick();
        resetn = 1'b1;
        tb_tail = 0;
        check_commit(0, "f_commit");
        chk("f_count0", bus.count, 0);
        chk("f_ready", bus.disp_ready, 1);
        chk("f_exc", bus.exc_valid, 0);
        tick();
        check_commit(0, "f_commit_late");
        chk("f_exc_late", bus.exc_valid, 0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_multi.md
ROB_MULTI -- requirements
Module: rob_multi

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entry count; power of 2, 4..64.
REQ-002 SHALL have parameter DISP_W, default 2: dispatch lanes per cycle, 1..4.
REQ-003 SHALL have parameter CMT_W, default 2: commit lanes per cycle, 1..4.
REQ-004 SHALL have parameter WB_W, default 2: writeback ports, 1..4.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port disp_valid  in  DISP_W  per-lane allocation request; lanes contiguous from lane 0.
REQ-008 SHALL have ports disp_pc  in  DISP_W x 32 and disp_dst  in  DISP_W x 5: entry PC and arch destination (0 = none).
REQ-009 SHALL have port disp_ready  out  1  high when free entries >= DISP_W.
REQ-010 SHALL have port disp_idx  out  DISP_W x log2(DEPTH)  index allocated to each lane.
REQ-011 SHALL have ports wb_valid  in  WB_W, wb_idx  in  WB_W x log2(DEPTH), wb_data  in  WB_W x 32, wb_exc  in  WB_W: completion writeback.
REQ-012 SHALL have port commit_stall  in  1  suppresses all commit and exception reporting this cycle.
REQ-013 SHALL have ports commit_valid  out  CMT_W, commit_dst  out  CMT_W x 5, commit_data  out  CMT_W x 32, commit_pc  out  CMT_W x 32.
REQ-014 SHALL have ports exc_valid  out  1 and exc_pc  out  32: precise exception at head.
REQ-015 SHALL have port flush  in  1  external pipeline flush.
REQ-016 SHALL have port count  out  log2(DEPTH)+1  occupied entries (registered).

Function
REQ-017 Storage: circular buffer, head/tail pointers log2(DEPTH)+1 bits (wrap bit); full when indices equal and wrap bits differ, empty when pointers equal.
REQ-018 Entry fields: valid, complete, exc, pc, dst, data.
REQ-019 disp_ready = (DEPTH - count) >= DISP_W, from registered count only; entries freed by commit this cycle are not reusable until next cycle.
REQ-020 Dispatch fires when disp_ready and disp_valid[0]; lane i writes entry tail+i (mod DEPTH), valid=1, complete=0, exc=0; tail advances by popcount(disp_valid).
REQ-021 disp_idx[i] = (tail+i) mod DEPTH, combinational from registered tail.
REQ-022 Writeback: port p with wb_valid sets complete=1, data, exc on entry wb_idx; writes to invalid entries ignored; same-index collisions resolved to highest port; effect visible to commit next cycle.
REQ-023 Commit lane k (combinational) asserts when !commit_stall, !flush, lanes 0..k-1 asserted, entry head+k valid, complete, exc=0, and k < count.
REQ-024 Committed entries cleared valid at edge; head advances by committed lane count.
REQ-025 exc_valid asserts when !commit_stall, !flush, head entry valid, complete, exc=1; exc_pc = that entry pc; commit_valid all 0 that cycle.
REQ-026 Cycle after exc_valid: all entries invalid, head=tail=0, count=0; dispatch in the exc_valid cycle discarded.
REQ-027 Exception behind committable entries: those commit first; exception reported when it reaches head.
REQ-028 flush: highest priority; next cycle all entries invalid, head=tail=0, count=0; no commit, no exception, dispatch discarded in flush cycle.
REQ-029 Simultaneous dispatch and commit: count_next = count + dispatched - committed; never exceeds DEPTH.
REQ-030 disp_dst=0 entries commit normally with commit_dst=0.

Reset
REQ-031 resetn low at edge: head=tail=0, count=0, all valid/complete/exc cleared; outputs next cycle: disp_ready=1, commit_valid=0, exc_valid=0, disp_idx[i]=i.
REQ-032 Reset mid-operation discards all entries and pending writebacks same edge; wb during reset ignored.

Verification (DEPTH=8, DISP_W=2, CMT_W=2, WB_W=2)
REQ-033 Dispatch 2 pc 0x100/0x104 dst 3/4; wb idx1 then idx0 data 0xA/0xB -> next cycle commit_valid=11, dst 3/4, data 0xB/0xA, count 2->0.
REQ-034 Fill 4 cycles x2 -> count=8, disp_ready=0; commit 2 -> next cycle ready=1; tail wraps, disp_idx=0/1.
REQ-035 Entries 0,1,2 complete, entry 1 exc=1 pc 0x204 -> commit lane0 only; next cycle exc_valid=1 exc_pc=0x204; following cycle count=0.
REQ-036 commit_stall=1 with 2 completed at head -> commit_valid=0, count unchanged; release -> both commit.
REQ-037 flush with 5 entries and concurrent dispatch/wb -> next cycle count=0, disp_idx=0/1, no commit.
REQ-038 resetn=0 for 1 cycle with 6 entries -> count=0, disp_ready=1, exc_valid=0.
